// File: rtl/score_pkg.sv
// Shared definitions for the score digit renderer.
//   GLYPH_W / GLYPH_H : glyph cell size in pixels
//   state_t           : conversion FSM states
//   pow10()           : constant helper for the overflow limit
//   GLYPH_ROM         : 16x16 digit font, 16 row words per digit, bit 15 = leftmost column
package score_pkg;

  localparam int unsigned GLYPH_W = 16;
  localparam int unsigned GLYPH_H = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

  // Seven-segment style strokes: bars span columns 5..10 (16'h07E0), the left
  // stroke is columns 5..6 (16'h0600), the right stroke columns 9..10 (16'h0060).
  // Row layout: 0 blank, 1-2 top, 3-6 upper, 7-8 middle, 9-12 lower, 13-14 bottom, 15 blank.
  localparam logic [15:0] GLYPH_ROM [160] = '{
    // 0
    16'h0000, 16'h07E0, 16'h07E0, 16'h0660, 16'h0660, 16'h0660, 16'h0660, 16'h0660,
    16'h0660, 16'h0660, 16'h0660, 16'h0660, 16'h0660, 16'h07E0, 16'h07E0, 16'h0000,
    // 1
    16'h0000, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060,
    16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0000,
    // 2
    16'h0000, 16'h07E0, 16'h07E0, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h07E0,
    16'h07E0, 16'h0600, 16'h0600, 16'h0600, 16'h0600, 16'h07E0, 16'h07E0, 16'h0000,
    // 3
    16'h0000, 16'h07E0, 16'h07E0, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h07E0,
    16'h07E0, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h07E0, 16'h07E0, 16'h0000,
    // 4
    16'h0000, 16'h0660, 16'h0660, 16'h0660, 16'h0660, 16'h0660, 16'h0660, 16'h07E0,
    16'h07E0, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0000,
    // 5
    16'h0000, 16'h07E0, 16'h07E0, 16'h0600, 16'h0600, 16'h0600, 16'h0600, 16'h07E0,
    16'h07E0, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h07E0, 16'h07E0, 16'h0000,
    // 6
    16'h0000, 16'h07E0, 16'h07E0, 16'h0600, 16'h0600, 16'h0600, 16'h0600, 16'h07E0,
    16'h07E0, 16'h0660, 16'h0660, 16'h0660, 16'h0660, 16'h07E0, 16'h07E0, 16'h0000,
    // 7
    16'h0000, 16'h07E0, 16'h07E0, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060,
    16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h0000,
    // 8
    16'h0000, 16'h07E0, 16'h07E0, 16'h0660, 16'h0660, 16'h0660, 16'h0660, 16'h07E0,
    16'h07E0, 16'h0660, 16'h0660, 16'h0660, 16'h0660, 16'h07E0, 16'h07E0, 16'h0000,
    // 9
    16'h0000, 16'h07E0, 16'h07E0, 16'h0660, 16'h0660, 16'h0660, 16'h0660, 16'h07E0,
    16'h07E0, 16'h0060, 16'h0060, 16'h0060, 16'h0060, 16'h07E0, 16'h07E0, 16'h0000
  };

endpackage

// File: rtl/score_glyph_rom.sv
// Registered glyph ROM for the score digit renderer.
// Ports:
//   Clk      : system clock (rising edge)
//   Reset    : synchronous active-high reset, clears the output register
//   i_digit  : BCD digit 0..9 (codes above 9 read as a blank row)
//   i_row    : glyph row 0..15
//   o_word   : registered 16-bit row word, bit 15 = leftmost column
module score_glyph_rom
  import score_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  i_digit,
  input  logic [3:0]  i_row,
  output logic [15:0] o_word
);

  logic [15:0] r_word;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_word <= '0;
    end else if (i_digit <= 4'd9) begin
      r_word <= GLYPH_ROM[{i_digit, i_row}];
    end else begin
      r_word <= '0;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/score_digit_renderer.sv
// Binary score to BCD converter (serial double dabble) with a 16x16 glyph renderer.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits on screen).
// Ports:
//   Clk, Reset   : rising-edge clock, synchronous active-high reset
//   score_in     : binary score, captured on score_load while idle
//   score_load   : one-cycle conversion request (ignored while busy)
//   busy         : conversion in progress (SCORE_W+1 cycles)
//   overflow     : last committed score did not fit in NUM_DIGITS digits
//   digits_out   : committed BCD digits, most significant in the top nibble
//   DrawX, DrawY : current pixel coordinates
//   pixel_on     : lit glyph pixel for the DrawX/DrawY presented two cycles earlier
module score_digit_renderer
  import score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned ORIGIN_X   = 0,
  parameter int unsigned ORIGIN_Y   = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [SCORE_W-1:0]      score_in,
  input  logic                    score_load,
  output logic                    busy,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic                    pixel_on
);

  localparam int unsigned DW    = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(SCORE_W);
  localparam logic [31:0] LIMIT = 32'(pow10(NUM_DIGITS));
  // 11-bit coordinates so the box edge past 1023 cannot wrap.
  localparam logic [10:0] OX    = 11'(ORIGIN_X);
  localparam logic [10:0] OY    = 11'(ORIGIN_Y);
  localparam logic [10:0] BOX_W = 11'(GLYPH_W * NUM_DIGITS);
  localparam logic [10:0] BOX_H = 11'(GLYPH_H);

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [SCORE_W-1:0] r_bin;
  logic [DW-1:0]      r_bcd;
  logic [DW-1:0]      w_bcd_adj;
  logic [DW-1:0]      r_digits;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;
  logic               r_busy;
  logic               r_overflow;

  // Only NUM_DIGITS nibbles are kept: any score that fits never carries past
  // them, and an overflowing score is replaced by all nines at commit.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_digits   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (score_load) begin
            r_bin      <= score_in;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (32'(score_in) >= LIMIT);
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(SCORE_W - 1)) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_digits   <= r_ovf_pend ? {NUM_DIGITS{4'h9}} : r_bcd;
          r_overflow <= r_ovf_pend;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign overflow   = r_overflow;
  assign digits_out = r_digits;

  // ---------------------------------------------------------------------------
  // Pixel pipeline, stage 1: box test, slot, glyph row and column
  // ---------------------------------------------------------------------------
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic        w_in_box;
  logic [2:0]  w_slot;
  logic [3:0]  w_col;
  logic [3:0]  w_row;

  assign w_x = {1'b0, DrawX};
  assign w_y = {1'b0, DrawY};
  assign w_in_box = (w_x >= OX) && (w_x < OX + BOX_W) && (w_y >= OY) && (w_y < OY + BOX_H);
  // Low nibble of the offset equals the difference of the low nibbles.
  assign w_col = DrawX[3:0] - OX[3:0];
  assign w_row = DrawY[3:0] - OY[3:0];

  always_comb begin
    w_slot = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (w_x >= OX + 11'(GLYPH_W * k)) begin
        w_slot = 3'(k);
      end
    end
  end

  logic       r1_in_box;
  logic [2:0] r1_slot;
  logic [3:0] r1_row;
  logic [3:0] r1_col;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r1_in_box <= 1'b0;
      r1_slot   <= '0;
      r1_row    <= '0;
      r1_col    <= '0;
    end else begin
      r1_in_box <= w_in_box;
      r1_slot   <= w_slot;
      r1_row    <= w_row;
      r1_col    <= w_col;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline, stage 2: digit lookup from the committed digits only
  // ---------------------------------------------------------------------------
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [15:0] w_word;

  // Slot 0 is the most significant digit, i.e. the top nibble.
  always_comb begin
    w_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r1_slot == 3'(k)) begin
        w_digit = r_digits[4*(NUM_DIGITS-1-k) +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A slot is blank when it and every slot to its left hold zero; the
  // rightmost slot is never blanked so a zero score still shows "0".
  always_comb begin
    logic v_lead;
    w_blank = 1'b0;
    v_lead  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      v_lead = v_lead && (r_digits[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      if ((k != NUM_DIGITS - 1) && v_lead && (r1_slot == 3'(k))) begin
        w_blank = 1'b1;
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  score_glyph_rom u_glyph_rom (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_digit (w_digit),
    .i_row   (r1_row),
    .o_word  (w_word)
  );

  logic       r2_on;
  logic [3:0] r2_col;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r2_on  <= 1'b0;
      r2_col <= '0;
    end else begin
      r2_on  <= r1_in_box && !w_blank;
      r2_col <= r1_col;
    end
  end

  assign pixel_on = r2_on && w_word[4'd15 - r2_col];

endmodule

// File: doc/score_digit_renderer.md
SCORE_DIGIT_RENDERER -- requirements
Module: score_digit_renderer

Interface
REQ-001 The block SHALL have the parameter NUM_DIGITS, default 4, giving the number of decimal digits displayed (legal range 1..8).
REQ-002 The block SHALL have the parameter SCORE_W, default 14, giving the binary score width (legal range 4..27).
REQ-003 The block SHALL have the parameters ORIGIN_X and ORIGIN_Y, default 0, giving the 10-bit screen coordinates of the top-left corner of the digit box.
REQ-004 The block SHALL have the port Clk, input, 1 bit: the single system clock; every flop SHALL be clocked on its rising edge.
REQ-005 The block SHALL have the port Reset, input, 1 bit: a synchronous, active-high reset.
REQ-006 The block SHALL have the port score_in, input, SCORE_W bits: the binary score to convert.
REQ-007 The block SHALL have the port score_load, input, 1 bit: a one-cycle request to convert score_in.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 The block SHALL have the port overflow, output, 1 bit: high when the last committed score did not fit in NUM_DIGITS digits.
REQ-010 The block SHALL have the port digits_out, output, 4*NUM_DIGITS bits: the committed BCD digits, most significant digit in the top nibble.
REQ-011 The block SHALL have the ports DrawX and DrawY, input, 10 bits each: the current pixel coordinates.
REQ-012 The block SHALL have the port pixel_on, output, 1 bit: high when the current pixel is a lit glyph pixel.

Function
REQ-013 The conversion FSM SHALL have the states IDLE, SHIFT and COMMIT.
REQ-014 When score_load=1 in IDLE, the FSM SHALL capture score_in and enter SHIFT.
REQ-015 SHIFT SHALL last exactly SCORE_W cycles, performing one double-dabble step per cycle (add 3 to any BCD nibble >=5, then shift left by 1).
REQ-016 COMMIT SHALL last one cycle: it SHALL update digits_out and overflow together in that cycle, then the FSM SHALL return to IDLE.
REQ-017 busy SHALL be high in SHIFT and COMMIT, for exactly SCORE_W+1 cycles per conversion; digits_out SHALL become valid on the cycle busy falls.
REQ-018 A score_load that arrives while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-019 If the captured score is >= 10^NUM_DIGITS, COMMIT SHALL set digits_out to all nines and overflow=1; otherwise it SHALL set overflow=0.
REQ-020 The digit box SHALL be 16*NUM_DIGITS pixels wide and 16 pixels high; digit slot k SHALL occupy columns ORIGIN_X+16k .. ORIGIN_X+16k+15, with k=0 the leftmost and most significant digit.
REQ-021 The pixel path SHALL be a 2-stage pipeline, and pixel_on SHALL correspond to the DrawX/DrawY value presented 2 cycles earlier.
REQ-022 Pipeline stage 1 SHALL register the in-box flag, the digit slot, the glyph row (DrawY-ORIGIN_Y) and the glyph column.
REQ-023 Pipeline stage 2 SHALL register the glyph-ROM row word for that slot's digit and row, and the pixel SHALL be bit 15-column of that word.
REQ-024 pixel_on SHALL be 0 for any coordinate outside the box, including coordinates left of or above the origin; the coordinate arithmetic SHALL NOT wrap.
REQ-025 The pixel path SHALL read the committed digits_out only, so a conversion in progress SHALL NOT disturb the display.
REQ-026 The pixel path SHALL run continuously, independent of the FSM state.
REQ-027 The glyph rows SHALL be the team's standard 16x16 digit font: digits 0-9 at 16 rows each, for 160 words of 16 bits.

Reset
REQ-028 While Reset=1 the block SHALL force the FSM to IDLE and hold busy=0, overflow=0, digits_out=0 and pixel_on=0.
REQ-029 While Reset=1 the block SHALL clear both pipeline stages.
REQ-030 A Reset during SHIFT or COMMIT SHALL abort the conversion without committing it.

Configuration
REQ-031 The feature macro SHALL be LEADING_ZERO_BLANK_EN.
REQ-032 With LEADING_ZERO_BLANK_EN defined, any zero digit to the left of the first non-zero digit SHALL render blank (pixel_on=0).
REQ-033 The least significant digit SHALL always render, even when LEADING_ZERO_BLANK_EN is defined.
REQ-034 LEADING_ZERO_BLANK_EN SHALL NOT change digits_out.
REQ-035 Without LEADING_ZERO_BLANK_EN, all NUM_DIGITS digits SHALL always render.

Structure
REQ-036 A shared package score_pkg SHALL hold GLYPH_W=16, GLYPH_H=16, the FSM state enum and the glyph ROM constant array.
REQ-037 A single sub-module score_glyph_rom SHALL hold the font: it SHALL map a 4-bit digit and a 4-bit row to a 16-bit word through a registered read (stage 2).

Verification
REQ-038 Conversion test: NUM_DIGITS=4, SCORE_W=14, score_in=1234 with a one-cycle score_load SHALL give busy for exactly 15 cycles, then digits_out=16'h1234 and overflow=0.
REQ-039 Overflow test: score_in=12000 SHALL give digits_out=16'h9999 and overflow=1; a following load of 0 SHALL give digits_out=16'h0000 and overflow=0.
REQ-040 Ignored-load test: loading 77 and then pulsing score_load with 55 on cycle 5 of that conversion SHALL commit 16'h0077 only, with no second busy period.
REQ-041 Pixel test: with digits 16'h0000 and ORIGIN=(100,50), DrawX=105, DrawY=52 SHALL give pixel_on=1 two cycles later; DrawX=104 SHALL give 0; DrawX=99 and DrawX=164 SHALL give 0.
REQ-042 Leading-zero test: with LEADING_ZERO_BLANK_EN defined and digits 16'h0007, slots 0-2 SHALL never light and slot 3 (X=ORIGIN_X+48..63) SHALL light per the glyph for 7; without the macro, slot 0 at (ORIGIN_X+5, ORIGIN_Y+2) SHALL light.
REQ-043 Reset test: asserting Reset for one cycle at cycle 7 of a conversion SHALL give busy=0 on the next cycle and leave digits_out=0, with no later commit.
